// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: default widths, op-code
// values, FSM state encoding, shift-direction encoding and small decode
// helpers used by both the top level and the iterative shifter.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int NBITS_DEF     = 32;
  localparam int ALUOP_DEF     = 4;
  localparam int SHAMTBITS_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_dir_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_dir_e shift_dir(input logic [3:0] op);
    case (op)
      ALU_SRL: return SH_RL;
      ALU_SRA: return SH_RA;
      default: return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// -----------------------------------------------------------------------------
// alu_shifter_iter
// Iterative barrel-free shifter: one bit position per unstalled clock.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_start  : load i_data/i_shamt/i_dir and begin shifting (i_shamt > 0)
//   i_stall  : hold all state
//   i_flush  : abort to idle (wins over stall)
//   i_dir, i_data, i_shamt : shift direction, operand, amount
//   o_busy   : a shift is in progress
//   o_done   : this edge performs the final shift step
//   o_result : work register after one more step (valid when o_done)
//   o_state  : FSM state for observation
// -----------------------------------------------------------------------------
module alu_shifter_iter
  import alu_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int SHAMTBITS = SHAMTBITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  shift_dir_e           i_dir,
  input  logic [NBITS-1:0]     i_data,
  input  logic [SHAMTBITS-1:0] i_shamt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NBITS-1:0]     o_result,
  output alu_state_e           o_state
);

  localparam logic [SHAMTBITS-1:0] CNT_LAST = SHAMTBITS'(1);

  alu_state_e           state_q, state_d;
  shift_dir_e           dir_q, dir_d;
  logic [NBITS-1:0]     work_q, work_d, work_step;
  logic [SHAMTBITS-1:0] cnt_q, cnt_d;

  // One-bit step of the current work value; SRA replicates the sign bit.
  always_comb begin
    case (dir_q)
      SH_LL:   work_step = {work_q[NBITS-2:0], 1'b0};
      SH_RL:   work_step = {1'b0, work_q[NBITS-1:1]};
      default: work_step = {work_q[NBITS-1], work_q[NBITS-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    o_done  = 1'b0;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else if (!i_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            work_d  = i_data;
            cnt_d   = i_shamt;
            dir_d   = i_dir;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_d = work_step;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      dir_q   <= SH_LL;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy   = (state_q == ST_SHIFT);
  assign o_result = work_step;
  assign o_state  = state_q;

endmodule

// File: rtl/ex_alu_stage.sv
// -----------------------------------------------------------------------------
// ex_alu_stage
// Execute-stage ALU: single-cycle logic/arith ops plus iterative shifts,
// with a registered result toward EX/MEM.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_Valid, i_ALUOp, i_A, i_B, i_Shamt : operation request from ID/EX
//   i_Stall : freeze the stage;  i_Flush : discard contents (wins over stall)
//   o_Result, o_Zero, o_Overflow, o_IllegalOp : registered result and flags
//   o_Valid : outputs hold a completed op (one cycle per op)
//   o_Busy  : iterative shift in progress
//
// Handshake: a request is taken on a rising edge when
// i_Valid && !o_Busy && !i_Stall && !i_Flush. There is no backpressure
// beyond o_Busy; the hazard unit must keep the request held while o_Busy is
// high, and o_Valid is a one-cycle completion pulse per accepted op.
// -----------------------------------------------------------------------------
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int ALUOP     = ALUOP_DEF,
  parameter int SHAMTBITS = SHAMTBITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_Valid,
  input  logic [ALUOP-1:0]     i_ALUOp,
  input  logic [NBITS-1:0]     i_A,
  input  logic [NBITS-1:0]     i_B,
  input  logic [SHAMTBITS-1:0] i_Shamt,
  input  logic                 i_Stall,
  input  logic                 i_Flush,
  output logic [NBITS-1:0]     o_Result,
  output logic                 o_Zero,
  output logic                 o_Overflow,
  output logic                 o_IllegalOp,
  output logic                 o_Valid,
  output logic                 o_Busy
);

  localparam int MSB = NBITS - 1;

  logic             accept, op_is_shift, shift_start;
  logic             shift_busy, shift_done;
  alu_state_e       shift_state;
  logic [NBITS-1:0] shift_result, alu_result, sum, diff;
  logic             alu_ovf, alu_illegal;

  logic [NBITS-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  assign accept      = i_Valid && !shift_busy && !i_Stall && !i_Flush;
  assign op_is_shift = is_shift_op(i_ALUOp);
  // A zero-amount shift is just a pass-through and completes in one cycle.
  assign shift_start = accept && op_is_shift && (i_Shamt != '0);

  assign sum  = i_A + i_B;
  assign diff = i_A - i_B;

  always_comb begin
    alu_result  = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (i_ALUOp)
      ALU_AND: alu_result = i_A & i_B;
      ALU_OR:  alu_result = i_A | i_B;
      ALU_NOR: alu_result = ~(i_A | i_B);
      ALU_XOR: alu_result = i_A ^ i_B;
      ALU_ADD: begin
        alu_result = sum;
        alu_ovf    = (i_A[MSB] == i_B[MSB]) && (sum[MSB] != i_A[MSB]);
      end
      ALU_SUB: begin
        alu_result = diff;
        alu_ovf    = (i_A[MSB] != i_B[MSB]) && (diff[MSB] != i_A[MSB]);
      end
      ALU_SLT: alu_result = {{(NBITS-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_result = i_B;
      default: alu_illegal = 1'b1;
    endcase
  end

  alu_shifter_iter #(
    .NBITS     (NBITS),
    .SHAMTBITS (SHAMTBITS)
  ) u_shifter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (shift_start),
    .i_stall  (i_Stall),
    .i_flush  (i_Flush),
    .i_dir    (shift_dir(i_ALUOp)),
    .i_data   (i_B),
    .i_shamt  (i_Shamt),
    .o_busy   (shift_busy),
    .o_done   (shift_done),
    .o_result (shift_result),
    .o_state  (shift_state)
  );

  // Flags stay with the last completed op while idle; they are cleared on
  // flush and whenever a shift starts or completes.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    if (i_Flush) begin
      ovf_d = 1'b0;
      ill_d = 1'b0;
    end else if (i_Stall) begin
      valid_d = valid_q;
    end else if (shift_done) begin
      result_d = shift_result;
      valid_d  = 1'b1;
      ovf_d    = 1'b0;
      ill_d    = 1'b0;
    end else if (accept) begin
      if (shift_start) begin
        ovf_d = 1'b0;
        ill_d = 1'b0;
      end else begin
        result_d = alu_result;
        valid_d  = 1'b1;
        ovf_d    = alu_ovf;
        ill_d    = alu_illegal;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign o_Result    = result_q;
  assign o_Zero      = (result_q == '0);
  assign o_Overflow  = ovf_q;
  assign o_IllegalOp = ill_q;
  assign o_Valid     = valid_q;
  assign o_Busy      = (shift_state == ST_SHIFT);

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [3:0]  i_aluop;
  logic [31:0] i_a, i_b;
  logic [4:0]  i_shamt;
  logic        i_stall, i_flush;
  logic [31:0] o_result;
  logic        o_zero, o_ovf, o_ill, o_valid, o_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ov;
    logic        il;
    int          edges;
  } vec_t;

  vec_t tbl[$];

  ex_alu_stage dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_Valid     (i_valid),
    .i_ALUOp     (i_aluop),
    .i_A         (i_a),
    .i_B         (i_b),
    .i_Shamt     (i_shamt),
    .i_Stall     (i_stall),
    .i_Flush     (i_flush),
    .o_Result    (o_result),
    .o_Zero      (o_zero),
    .o_Overflow  (o_ovf),
    .o_IllegalOp (o_ill),
    .o_Valid     (o_valid),
    .o_Busy      (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the op semantics.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ov,
                                output logic il, output int edges);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r = 32'h0; ov = 1'b0; il = 1'b0; edges = 0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b1101: r = a ^ b;
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin r = b << sh; edges = int'(sh); end
      4'b1001: begin r = b >> sh; edges = int'(sh); end
      4'b1010: begin r = $unsigned($signed(b) >>> sh); edges = int'(sh); end
      default: il = 1'b1;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Accept happens on the edge after the drive; 'edges' is the count of
  // further edges until o_Valid is expected.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic eo, input logic ei, input int edges);
    logic [31:0] exp_r;
    exp_q.push_back(er);
    @(negedge clk);
    i_valid = 1'b1; i_aluop = op; i_a = a; i_b = b; i_shamt = sh;
    @(negedge clk);
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_shamt = 5'($urandom);
    for (int j = 0; j <= edges; j++) begin
      if (j < edges) begin
        check({name, " busy"}, o_busy, 1'b1);
        check({name, " valid_early"}, o_valid, 1'b0);
        @(negedge clk);
      end else begin
        exp_r = exp_q.pop_front();
        check({name, " valid"}, o_valid, 1'b1);
        check({name, " busy_done"}, o_busy, 1'b0);
        check({name, " result"}, o_result, exp_r);
        check({name, " zero"}, o_zero, (exp_r == 32'h0));
        check({name, " ovf"}, o_ovf, eo);
        check({name, " illegal"}, o_ill, ei);
      end
    end
    @(negedge clk);
    check({name, " valid_drop"}, o_valid, 1'b0);
    check({name, " result_hold"}, o_result, er);
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] r,
                         input logic ov, input logic il, input int edges);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.r = r; v.ov = ov; v.il = il; v.edges = edges;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, rr;
    logic [4:0]  rsh;
    logic        rov, ril;
    int          redges;
    logic [3:0]  op_pool[16];

    add_vec("add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0, 0);
    add_vec("add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0, 0);
    add_vec("sub_zero",  4'b0110, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0, 0);
    add_vec("sub_ovf",   4'b0110, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 0);
    add_vec("sub_ovf2",  4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0, 0);
    add_vec("slt_true",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 0);
    add_vec("slt_false", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0, 0);
    add_vec("and",       4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 1'b0, 1'b0, 0);
    add_vec("or",        4'b0001, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 1'b0, 1'b0, 0);
    add_vec("nor",       4'b1100, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0);
    add_vec("xor",       4'b1101, 32'h000000FF, 32'h0000000F, 5'd0,  32'h000000F0, 1'b0, 1'b0, 0);
    add_vec("ill_1111",  4'b1111, 32'h00000123, 32'h00000456, 5'd3,  32'h00000000, 1'b0, 1'b1, 0);
    add_vec("ill_0011",  4'b0011, 32'hDEADBEEF, 32'h00000456, 5'd0,  32'h00000000, 1'b0, 1'b1, 0);
    add_vec("sra_4",     4'b1010, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 4);
    add_vec("sll_0",     4'b1000, 32'h0,        32'h00001234, 5'd0,  32'h00001234, 1'b0, 1'b0, 0);
    add_vec("srl_31",    4'b1001, 32'h0,        32'h80000001, 5'd31, 32'h00000001, 1'b0, 1'b0, 31);
    add_vec("sll_31",    4'b1000, 32'h0,        32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 31);
    add_vec("sra_1",     4'b1010, 32'h0,        32'h7FFFFFFF, 5'd1,  32'h3FFFFFFF, 1'b0, 1'b0, 1);

    i_valid = 1'b0; i_aluop = 4'h0; i_a = 32'h0; i_b = 32'h0; i_shamt = 5'd0;
    i_stall = 1'b0; i_flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", o_result, 32'h0);
    check("rst_zero", o_zero, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_ill", o_ill, 1'b0);
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
             tbl[i].r, tbl[i].ov, tbl[i].il, tbl[i].edges);

    // Stall two cycles in the middle of SRL 0xF0 by 3
    run_op("pre_stall", 4'b0010, 32'h11, 32'h22, 5'd0, 32'h33, 1'b0, 1'b0, 0);
    @(negedge clk);
    i_valid = 1'b1; i_aluop = 4'b1001; i_b = 32'hF0; i_shamt = 5'd3;
    @(negedge clk);
    i_valid = 1'b0; i_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("stall busy", o_busy, 1'b1);
      check("stall valid", o_valid, 1'b0);
      check("stall result_hold", o_result, 32'h33);
      if (j < 2) @(negedge clk);
    end
    i_stall = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("stall post busy", o_busy, 1'b1);
      check("stall post valid", o_valid, 1'b0);
    end
    @(negedge clk);
    check("stall done valid", o_valid, 1'b1);
    check("stall done result", o_result, 32'h1E);
    check("stall done busy", o_busy, 1'b0);

    // Flush during a shift, then a normal ADD
    @(negedge clk);
    i_valid = 1'b1; i_aluop = 4'b1000; i_b = 32'h1; i_shamt = 5'd10;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b1;
    check("flush pre busy", o_busy, 1'b1);
    @(negedge clk);
    i_flush = 1'b0;
    check("flush busy", o_busy, 1'b0);
    check("flush valid", o_valid, 1'b0);
    repeat (12) begin
      @(negedge clk);
      check("flush stays invalid", o_valid, 1'b0);
    end
    run_op("post_flush_add", 4'b0010, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1'b0, 0);

    // Flush clears held flags of an illegal op
    run_op("ill_pre_flush", 4'b1110, 32'h1, 32'h2, 5'd0, 32'h0, 1'b0, 1'b1, 0);
    check("ill held", o_ill, 1'b1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush clears ill", o_ill, 1'b0);

    // Async reset in the middle of a shift
    run_op("pre_reset", 4'b0110, 32'h9, 32'h2, 5'd0, 32'h7, 1'b0, 1'b0, 0);
    @(negedge clk);
    i_valid = 1'b1; i_aluop = 4'b1010; i_b = 32'h80000000; i_shamt = 5'd20;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    check("prereset busy", o_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst result", o_result, 32'h0);
    check("arst zero", o_zero, 1'b1);
    check("arst busy", o_busy, 1'b0);
    check("arst valid", o_valid, 1'b0);
    check("arst ovf", o_ovf, 1'b0);
    check("arst ill", o_ill, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_add", 4'b0010, 32'h40, 32'h2, 5'd0, 32'h42, 1'b0, 1'b0, 0);

    // Randomized ops against the reference model
    op_pool = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101,
                4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b0110, 4'b0011, 4'b1011,
                4'b1110, 4'b1111};
    for (int i = 0; i < 60; i++) begin
      rop = op_pool[$urandom_range(0, 15)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = {ra[31], 31'h7FFFFFFF};
        rb = {rb[31], 31'h00000000};
      end
      rsh = 5'($urandom_range(0, 31));
      model(rop, ra, rb, rsh, rr, rov, ril, redges);
      run_op($sformatf("rand%0d_op%h", i, rop), rop, ra, rb, rsh, rr, rov, ril, redges);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU for the MIPS pipeline; consumes the 4-bit operation code produced by the ALU control decoder plus the two operands from ID/EX. It registers its result toward EX/MEM, honours pipeline stall and flush, and raises a busy signal to the hazard unit. Single-cycle ops complete in one cycle. Shifts run iteratively, one bit per cycle, so the hazard unit must hold the pipeline while they run.

## Interface
- NBITS, 32, operand/result width
- ALUOP, 4, operation code width
- SHAMTBITS, 5, shift-amount width
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_Valid  in  1  operands/op present this cycle
- i_ALUOp  in  ALUOP  operation code
- i_A  in  NBITS  operand A (rs)
- i_B  in  NBITS  operand B (rt or extended immediate)
- i_Shamt  in  SHAMTBITS  shift amount
- i_Stall  in  1  downstream stall; freeze stage
- i_Flush  in  1  discard stage contents
- o_Result  out  NBITS  registered result
- o_Zero  out  1  o_Result == 0
- o_Overflow  out  1  signed overflow on add/sub
- o_IllegalOp  out  1  unrecognised op code
- o_Valid  out  1  outputs hold a completed op
- o_Busy  out  1  iterative shift in progress (combinational from state)

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed A<B → 1 else 0), 1100 NOR, 1101 XOR.
- Shift op codes operate on i_B by i_Shamt: 1000 SLL, 1001 SRL, 1010 SRA.
- Any other code: result 0, o_IllegalOp=1, o_Valid=1.
- ADD/SUB use modulo 2^NBITS arithmetic.
- o_Overflow is set only for ADD/SUB when the operand signs imply a sign-flipped result; it is 0 for all other ops. It is a flag only; trapping is decided downstream.
- Accept condition: i_Valid && !o_Busy && !i_Stall && !i_Flush.
- FSM states: IDLE, SHIFT.
- IDLE, accepting a non-shift op (or a shift with i_Shamt=0): result registered, o_Valid=1; stay IDLE.
- IDLE, accepting a shift with i_Shamt>0: load work←i_B, cnt←i_Shamt; o_Valid←0; go to SHIFT.
- SHIFT, each unstalled edge: shift work by 1 in the selected direction (SRA replicates bit NBITS-1); cnt←cnt-1.
- SHIFT, edge where cnt==1: register the final value to o_Result, set o_Valid=1, return to IDLE.
- IDLE without an accept: o_Valid←0 next edge; o_Result holds its last value.
- i_Stall=1: every register holds, including the shift state and count.
- i_Flush=1: next edge o_Valid←0, o_IllegalOp←0, o_Overflow←0, and the FSM goes to IDLE, aborting any shift. Flush has priority over stall.
- Reset mid-shift: immediate abort to IDLE.

## Timing
- Reset value of every output: 0 (o_Result=0, o_Zero=1 since it derives from o_Result, o_Busy=0).
- Single-cycle op accepted at edge k → o_Valid high in the cycle after edge k.
- Shift with shamt n≥1 accepted at edge k:
  - o_Busy high from edge k through edge k+n;
  - o_Valid high after edge k+n, so latency is n cycles;
  - each stall cycle adds one cycle.
- A new op is accepted on the same edge that completes a shift only if o_Busy is already low, i.e. never. The earliest next accept is the edge after completion.
- o_Zero, o_Overflow and o_IllegalOp are registered alongside o_Result and are meaningful only when o_Valid=1.

## Structure
- Package alu_pkg holds:
  - op-code localparams (ALU_AND … ALU_SRA);
  - state encoding (ST_IDLE, ST_SHIFT);
  - the default widths.
- Sub-module alu_shifter_iter holds the work register, counter, direction and done pulse. It exposes start/stall/flush/done/busy.
- The top level holds the combinational single-cycle datapath and the output registers.

## Test plan
- Single-cycle ops: ADD 0x7FFFFFFF+1 → 0x80000000, o_Overflow=1; SUB 5-5 → 0, o_Zero=1; SLT -1<1 → 1.
- SRA 0x80000000 by 4 → 0xF8000000: o_Busy high for 4 cycles, o_Valid exactly 4 cycles after accept.
- SLL by 0 on 0x1234 → 0x1234 after 1 cycle with o_Busy never asserted.
- Stall 2 cycles mid SRL of 0xF0 by 3 → 0x1E with latency 5; o_Result held during the stall.
- Flush during SHIFT → o_Valid stays 0, o_Busy drops next cycle, a following ADD completes normally.
- Illegal code 1111 → o_Result=0, o_IllegalOp=1; async reset asserted mid-shift → all outputs 0 immediately.
